alu_issue: RTL and testbench



---
 rtl/alu_issue_if.sv | 26 ++
 rtl/alu_issue.sv | 135 +++++++++++++
 tb/tb_alu_issue.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Upstream issue and writeback handshakes of the ALU issue sequencer.
// slave is the sequencer side; master is the producer/consumer side.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic [4:0]  out_tag;
  logic        out_div_zero;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_tag, out_div_zero
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_tag, out_div_zero
  );
endinterface

// File: rtl/alu_issue.sv
// Execute-stage issue sequencer: holds operands on the ALU for a per-op cycle
// count, captures the result and hands it to writeback with its tag.
module alu_issue #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_issue_if.slave        io,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_sel,
  input  logic [31:0]       alu_out,
  input  logic              alu_carry
);

  // state  | meaning
  // S_IDLE | no op held, ready to accept
  // S_EXEC | operands on the ALU, counter running down to capture
  // S_DONE | result presented to writeback, waiting for out_ready

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
    $error("alu_issue: MUL_CYCLES must be within 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
    $error("alu_issue: DIV_CYCLES must be within 1..15");
  end

  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  sel_q;
  logic [4:0]  tag_q;
  logic        dz_q;
  logic        valid_q;
  logic [31:0] res_q;
  logic        carry_q;
  logic [4:0]  otag_q;
  logic        odz_q;

  logic        ready;
  logic        accept;
  logic        in_dz;
  logic [3:0]  load_cnt;

  assign ready  = !flush && ((state == S_IDLE) || ((state == S_DONE) && io.out_ready));
  assign accept = io.in_valid && ready;
  assign in_dz  = (io.in_op == OP_DIV) && (io.in_b == 32'd0);

  // A divide by zero skips the multicycle hold since its result is forced.
  always_comb begin
    load_cnt = 4'd1;
    if (!in_dz) begin
      if (io.in_op == OP_DIV) begin
        load_cnt = 4'(DIV_CYCLES);
      end else if (io.in_op == OP_MUL) begin
        load_cnt = 4'(MUL_CYCLES);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sel_q   <= 4'd0;
      tag_q   <= 5'd0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= 32'd0;
      carry_q <= 1'b0;
      otag_q  <= 5'd0;
      odz_q   <= 1'b0;
    end else if (flush) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_EXEC: begin
          if (cnt == 4'd1) begin
            res_q   <= dz_q ? 32'hFFFF_FFFF : alu_out;
            carry_q <= alu_carry;
            otag_q  <= tag_q;
            odz_q   <= dz_q;
            valid_q <= 1'b1;
            cnt     <= 4'd0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Accept is only possible from IDLE or a draining DONE, so it overrides the case above.
      if (accept) begin
        a_q   <= io.in_a;
        b_q   <= io.in_b;
        sel_q <= io.in_op;
        tag_q <= io.in_tag;
        dz_q  <= in_dz;
        cnt   <= load_cnt;
        state <= S_EXEC;
      end
    end
  end

  assign io.in_ready     = ready;
  assign io.out_valid    = valid_q;
  assign io.out_result   = res_q;
  assign io.out_carry    = carry_q;
  assign io.out_tag      = otag_q;
  assign io.out_div_zero = odz_q;

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a timing-aware ALU model, directed cases
// from the plan, then randomized traffic with flush and backpressure.
module tb_alu_issue;
  localparam int MUL = 2;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_carry;

  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .io(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return a << b[4:0];
      4'h8: return a >> b[4:0];
      4'hF: return {31'd0, a == b};
      default: return a ^ b ^ {28'd0, op};
    endcase
  endfunction

  function automatic logic alu_cy(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (op == 4'h0) return s[32];
    if (op == 4'h1) return a >= b;
    return 1'b0;
  endfunction

  function automatic int op_cycles(input logic [3:0] op);
    if (op == 4'h2) return MUL;
    if (op == 4'h3) return DIV;
    return 1;
  endfunction

  // ALU model: mul/div only settle once inputs have been stable long enough.
  logic [31:0] pa = '0, pb = '0;
  logic [3:0]  ps = '0;
  int          held = 0;
  int          eff;
  always @(posedge clk) begin
    if ({alu_a, alu_b, alu_sel} == {pa, pb, ps}) held <= held + 1;
    else held <= 1;
    pa <= alu_a;
    pb <= alu_b;
    ps <= alu_sel;
  end
  assign eff       = ({alu_a, alu_b, alu_sel} == {pa, pb, ps}) ? held : 0;
  assign alu_out   = (eff >= op_cycles(alu_sel) - 1) ? alu_fn(alu_sel, alu_a, alu_b) : 32'hBAD0_BAD0;
  assign alu_carry = alu_cy(alu_sel, alu_a, alu_b);

  typedef struct {
    logic [31:0] a, b, res;
    logic [3:0]  op;
    logic [4:0]  tag;
    logic        cy, dz;
    int          lat, acc;
  } exp_t;

  exp_t q[$];
  bit   fpres = 1'b0;
  int   fwait = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t build(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag, input int acc);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.tag = tag; e.acc = acc;
    e.dz  = (op == 4'h3) && (b == 32'd0);
    e.res = e.dz ? 32'hFFFF_FFFF : alu_fn(op, a, b);
    e.cy  = alu_cy(op, a, b);
    e.lat = e.dz ? 1 : op_cycles(op);
    return e;
  endfunction

  task automatic pop_front_item;
    void'(q.pop_front());
    fpres = 1'b0;
    fwait = 0;
  endtask

  // Monitor: compares what the DUT presents, then books the events of the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      fpres = 1'b0;
      fwait = 0;
    end else begin
      if (q.size() == 0) begin
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_ready", 32'(bus.in_ready), 32'(!flush));
      end else if (!bus.out_valid) begin
        if (fpres) begin
          chk("valid_dropped", 32'(bus.out_valid), 32'd1);
          pop_front_item();
        end else begin
          fwait++;
          chk("exec_ready", 32'(bus.in_ready), 32'd0);
          chk("exec_hold_a", alu_a, q[0].a);
          chk("exec_hold_b", alu_b, q[0].b);
          chk("exec_hold_sel", 32'(alu_sel), 32'(q[0].op));
          if (fwait > 40) begin
            chk("exec_timeout", 32'(bus.out_valid), 32'd1);
            pop_front_item();
          end
        end
      end else begin
        if (!fpres) begin
          chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          fpres = 1'b1;
        end
        chk("result", bus.out_result, q[0].res);
        chk("carry", 32'(bus.out_carry), 32'(q[0].cy));
        chk("tag", 32'(bus.out_tag), 32'(q[0].tag));
        chk("div_zero", 32'(bus.out_div_zero), 32'(q[0].dz));
        chk("done_ready", 32'(bus.in_ready), 32'(!flush && bus.out_ready));
      end
      if (flush) begin
        if (q.size() > 0) pop_front_item();
      end else begin
        if (bus.out_valid && bus.out_ready && q.size() > 0 && fpres) pop_front_item();
        if (bus.in_valid && bus.in_ready)
          q.push_back(build(bus.in_op, bus.in_a, bus.in_b, bus.in_tag, cyc + 1));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    tick();
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        bus.in_valid = 1'b0;
        return;
      end
    end
    chk("issue_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n - 1;
        return;
      end
    end
  endtask

  int  lat;
  bit  seen;

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    #23 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_misc", {25'd0, bus.out_tag, bus.out_carry, bus.out_div_zero}, 32'd0);
    chk("rst_alu", alu_a | alu_b | {28'd0, alu_sel}, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    issue(4'h0, 32'd5, 32'd7, 5'd3);
    wait_out(lat);
    chk("add_lat", 32'(lat), 32'd1);
    chk("add_res", bus.out_result, 32'd12);
    chk("add_flags", {25'd0, bus.out_tag, bus.out_carry, bus.out_div_zero}, {25'd0, 5'd3, 1'b0, 1'b0});

    issue(4'h0, 32'hFFFF_FFFF, 32'd1, 5'd4);
    wait_out(lat);
    chk("ovf_res", bus.out_result, 32'd0);
    chk("ovf_carry", 32'(bus.out_carry), 32'd1);

    issue(4'h3, 32'd100, 32'd7, 5'd8);
    chk("div_busy", 32'(bus.in_ready), 32'd0);
    chk("div_sel", 32'(alu_sel), 32'd3);
    wait_out(lat);
    chk("div_lat", 32'(lat), 32'd4);
    chk("div_res", bus.out_result, 32'd14);

    issue(4'h3, 32'd9, 32'd0, 5'd10);
    wait_out(lat);
    chk("dz_lat", 32'(lat), 32'd1);
    chk("dz_res", bus.out_result, 32'hFFFF_FFFF);
    chk("dz_flag", 32'(bus.out_div_zero), 32'd1);

    tick();
    bus.out_ready = 1'b0;
    issue(4'h0, 32'd1, 32'd2, 5'd11);
    wait_out(lat);
    tick();
    bus.in_valid = 1'b1; bus.in_op = 4'h1; bus.in_a = 32'd10; bus.in_b = 32'd3; bus.in_tag = 5'd12;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stable", {bus.out_result[26:0], bus.out_tag}, {27'd3, 5'd11});
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    tick();
    bus.out_ready = 1'b1;
    #1 chk("b2b_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_lat", 32'(lat), 32'd1);
    chk("b2b_res", bus.out_result, 32'd7);

    issue(4'h2, 32'd6, 32'd7, 5'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);

    tick();
    bus.out_ready = 1'b0;
    issue(4'h0, 32'hFFFF_FFFF, 32'd2, 5'd14);
    wait_out(lat);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out", bus.out_result | {25'd0, bus.out_tag, bus.out_carry, bus.out_div_zero}, 32'd0);
    chk("arst_alu", alu_a | alu_b | {28'd0, alu_sel}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      int r;
      tick();
      flush = ($urandom_range(0, 29) == 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 5);
      bus.in_op = (r < 4) ? 4'(r) : 4'($urandom_range(0, 15));
      bus.in_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      if ($urandom_range(0, 7) == 0) bus.in_b = 32'd0;
      else if (bus.in_op == 4'h3) bus.in_b = 32'($urandom_range(1, 20));
      else bus.in_b = $urandom;
      bus.in_tag = 5'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    tick();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (30) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
